aes_encrypt: RTL
================

# aes_encrypt

Iterative AES-128 encryption core, the forward counterpart of the lab's decryption core; it shares that core's START/DONE handshake so both can sit behind the same Avalon register file. It latches a 128-bit key and plaintext on start and runs the 10 FIPS-197 rounds at 4 cycles per round. Round keys are expanded on the fly, so no 1408-bit schedule is stored. The result is held in a register until the host drops START.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high.
- AES_START  in  1  level request; sampled only in WAIT and HOLD.
- AES_KEY  in  128  cipher key; byte 0 at [127:120].
- AES_MSG_PT  in  128  plaintext; byte 0 at [127:120].
- AES_DONE  out  1  registered; high while result is valid and START is still high.
- AES_MSG_ENC  out  128  registered ciphertext.

## Operation
- State layout: FIPS-197 column-major order, with byte 0 at [127:120]. Column c occupies bits [127-32c -: 32], and row r is byte r of each column.
- Internal registers:
  - st (128): state.
  - rk (128): current round key.
  - round (4).
  - rcon (8).
  - Sub-box output register sb (128 + 32).
- S-box: 20 forward S-box lookups (16 state bytes plus 4 key bytes), each registered with 1-cycle read latency. Lookup address is presented in SUB; data is valid in SUBW.
- FSM states: WAIT, SUB, SUBW, MIX, ARK, HOLD.
- WAIT: if AES_START=1, then on the next edge:
  - st <= AES_MSG_PT ^ AES_KEY (AddRoundKey 0)
  - rk <= AES_KEY, round <= 1, rcon <= 8'h01
  - go to SUB
- SUB: S-box addresses = st bytes and RotWord(rk[31:0]). Next state is SUBW.
- SUBW:
  - st <= SubBytes(st).
  - Next round key, with w0..w3 = rk[127:96]..rk[31:0]:
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
  - rk <= {w0',w1',w2',w3'}. Next state is MIX.
- MIX: st <= ShiftRows(st), where row r is rotated left by r bytes. If round != 10, MixColumns is also applied in the same cycle (GF(2^8), poly 0x11B, matrix rows 02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02). Next state is ARK.
- ARK: st <= st ^ rk.
  - If round == 10: AES_MSG_ENC <= st ^ rk, AES_DONE <= 1, go to HOLD.
  - Else: round <= round+1, rcon <= xtime(rcon), go to SUB.
  - xtime sequence: 01,02,04,08,10,20,40,80,1B,36.
- HOLD: AES_DONE=1 while START=1. When START=0, on the next edge AES_DONE <= 0 and state goes to WAIT.
- AES_MSG_ENC holds its value until the next completion; it is not cleared on return to WAIT.

## Timing
- Reset values: state=WAIT, AES_DONE=0, AES_MSG_ENC=0, round=0, rcon=8'h01, st=0, rk=0.
- Latency: START is sampled high in WAIT at edge E0. AES_DONE and AES_MSG_ENC update at edge E0+40 (10 rounds × 4 cycles).
- Inputs are sampled only at E0. Changes to AES_KEY or AES_MSG_PT after E0 do not affect the operation in flight.
- START dropping mid-operation is ignored: encryption completes, DONE rises at E0+40, and DONE falls one edge later because START is low in HOLD. DONE is therefore high for at least 1 cycle.
- START held high after DONE: the core stays in HOLD and does not restart. A new operation requires START low, then high.
- RESET asserted in any state takes effect at the next edge: WAIT, DONE=0, AES_MSG_ENC=0. The operation in flight is discarded.
- RESET and START high on the same edge: RESET wins, and the core enters WAIT.
- The next operation can begin at the earliest 2 edges after START falls (HOLD→WAIT, then WAIT samples START).

## Test plan
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, START held high.
  - Required: AES_MSG_ENC = 69c4e0d86a7b0430d8cdb78070b4c55a and DONE=1, exactly at E0+40.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32, and internal rk at round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Handshake:
  - Stimulus: run vector B, hold START high for 10 cycles after DONE, then drop it; next, START pulsed for 1 cycle only.
  - Required: DONE stays 1 until the edge after START=0, then 0; AES_MSG_ENC is retained. With the 1-cycle START pulse, the run still completes and DONE is high for exactly 1 cycle.
- Input change mid-run:
  - Stimulus: start vector C.1, then change AES_KEY and AES_MSG_PT to all-ones at E0+5.
  - Required: result is still 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reset mid-run:
  - Stimulus: assert RESET at E0+20 for 1 cycle, then start vector B.
  - Required: DONE=0 and AES_MSG_ENC=0 after reset; the second run gives 3925841d02dc09fbdc118597196a0b32 at its own E0+40.
- Back-to-back:
  - Stimulus: run C.1 then B with the minimum START-low gap (1 cycle).
  - Required: both results correct, with no carry-over of rcon, round or rk.

Source files
------------

// File: rtl/aes_encrypt.sv
// ---------------------------------------------------------------------------
// aes_encrypt
// Iterative AES-128 encryption core. Each round takes four cycles
// (SUB -> SUBW -> MIX -> ARK). The round keys are expanded one round at a
// time alongside the state, so the full key schedule is never stored.
// It uses the same START/DONE level handshake as the decryption core.
//
// Ports
//   CLK          in   1    clock; all state updates on the rising edge
//   RESET        in   1    synchronous, active-high
//   AES_START    in   1    level request; sampled only in WAIT and HOLD
//   AES_KEY      in   128  cipher key, byte 0 at [127:120]
//   AES_MSG_PT   in   128  plaintext, byte 0 at [127:120]
//   AES_DONE     out  1    registered; high while the result is valid and
//                          START is still high
//   AES_MSG_ENC  out  128  registered ciphertext; held until next completion
// ---------------------------------------------------------------------------
module aes_encrypt (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_PT,
  output logic         AES_DONE,
  output logic [127:0] AES_MSG_ENC
);

  typedef enum logic [2:0] {WAIT, SUB, SUBW, MIX, ARK, HOLD} state_t;

  state_t         state_reg, state_next;
  logic [127:0]   st_reg;
  logic [127:0]   rk_reg;
  logic [3:0]     round_reg;
  logic [7:0]     rcon_reg;
  logic [159:0]   sb_reg;      // [159:32] SubBytes(st), [31:0] SubWord(RotWord(w3))
  logic [159:0]   sbox_addr;
  logic [159:0]   sbox_data;

  // Datapath control strobes decoded from the FSM state
  logic load_en, subw_en, mix_en, ark_en, last_round;

  // -------------------------------------------------------------------------
  // GF(2^8) helpers (reduction polynomial 0x11B)
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; the zero input maps to zero on its own.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the FIPS-197 affine transform
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // Row r of the column-major state is rotated left by r bytes
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c      -: 8];
      a1 = s[127 - 32*c - 8  -: 8];
      a2 = s[127 - 32*c - 16 -: 8];
      a3 = s[127 - 32*c - 24 -: 8];
      o[127 - 32*c      -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127 - 32*c - 8  -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127 - 32*c - 24 -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  // -------------------------------------------------------------------------
  // S-box bank: 16 state bytes plus RotWord(w3). The address is whatever the
  // registers hold in SUB; the registered data is consumed in SUBW.
  // -------------------------------------------------------------------------
  assign sbox_addr = {st_reg, rk_reg[23:0], rk_reg[31:24]};

  generate
    for (genvar gi = 0; gi < 20; gi++) begin : g_sbox
      assign sbox_data[159 - 8*gi -: 8] = sbox_byte(sbox_addr[159 - 8*gi -: 8]);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    sb_reg <= sbox_data;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= WAIT;
    else       state_reg <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT:    if (AES_START) state_next = SUB;
      SUB:     state_next = SUBW;
      SUBW:    state_next = MIX;
      MIX:     state_next = ARK;
      ARK:     state_next = (round_reg == 4'd10) ? HOLD : SUB;
      HOLD:    if (!AES_START) state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  // FSM: output decode
  always_comb begin
    load_en    = 1'b0;
    subw_en    = 1'b0;
    mix_en     = 1'b0;
    ark_en     = 1'b0;
    last_round = (round_reg == 4'd10);
    case (state_reg)
      WAIT:    load_en = AES_START;
      SUBW:    subw_en = 1'b1;
      MIX:     mix_en  = 1'b1;
      ARK:     ark_en  = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  logic [31:0]  w0_next, w1_next, w2_next, w3_next;
  logic [127:0] shifted;

  always_comb begin
    w0_next = rk_reg[127:96] ^ sb_reg[31:0] ^ {rcon_reg, 24'h000000};
    w1_next = rk_reg[95:64] ^ w0_next;
    w2_next = rk_reg[63:32] ^ w1_next;
    w3_next = rk_reg[31:0]  ^ w2_next;
    shifted = shift_rows(st_reg);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_reg      <= '0;
      rk_reg      <= '0;
      round_reg   <= 4'd0;
      rcon_reg    <= 8'h01;
      AES_MSG_ENC <= '0;
      AES_DONE    <= 1'b0;
    end else begin
      if (load_en) begin
        st_reg    <= AES_MSG_PT ^ AES_KEY;
        rk_reg    <= AES_KEY;
        round_reg <= 4'd1;
        rcon_reg  <= 8'h01;
      end
      if (subw_en) begin
        st_reg <= sb_reg[159:32];
        rk_reg <= {w0_next, w1_next, w2_next, w3_next};
      end
      if (mix_en) begin
        // The final round skips MixColumns
        st_reg <= last_round ? shifted : mix_columns(shifted);
      end
      if (ark_en) begin
        st_reg <= st_reg ^ rk_reg;
        if (last_round) begin
          AES_MSG_ENC <= st_reg ^ rk_reg;
        end else begin
          round_reg <= round_reg + 4'd1;
          rcon_reg  <= xtime(rcon_reg);
        end
      end
      // DONE tracks residence in HOLD: rises on completion, falls when START drops
      AES_DONE <= (state_next == HOLD);
    end
  end

endmodule
